phys_reg_free_list: RTL

Free-list controller for the out-of-order core's 64-entry physical register file. Rename allocates physical destination tags from this block, and commit returns retired tags to it. A committed-head pointer lets a pipeline flush restore all speculatively allocated tags in one cycle. The block sits between the decode/rename stage, which requests tags, and the ROB commit port, which returns and retires them.

---
 rtl/phys_reg_free_list_pkg.sv | 16 +
 rtl/phys_reg_free_list_if.sv | 23 ++
 rtl/phys_reg_free_list.sv | 56 +++++
 3 files changed

// File: rtl/phys_reg_free_list_pkg.sv
// phys_reg_free_list_pkg: rename-side sizing, tag and free-list pointer types
package phys_reg_free_list_pkg;
    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int PHY_W    = $clog2(NUM_PHYS);
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
    localparam int PTR_W    = $clog2(DEPTH) + 1;

    typedef logic [PHY_W-1:0] phy_tag_t;
    typedef logic [PTR_W-1:0] free_ptr_t;

    // Storage index: pointer with the wrap bit stripped
    function automatic logic [PTR_W-2:0] ptr_idx(free_ptr_t p);
        return p[PTR_W-2:0];
    endfunction
endpackage

// File: rtl/phys_reg_free_list_if.sv
// phys_reg_free_list_if: rename/commit side bundle of the physical tag free list
interface phys_reg_free_list_if;
    import phys_reg_free_list_pkg::*;
    logic             alloc_req;
    logic             alloc_gnt;
    phy_tag_t         alloc_phy;
    logic             commit_alloc;
    logic             free_valid;
    phy_tag_t         free_phy;
    logic             flush;
    logic             empty;
    logic [PHY_W:0]   free_count;
    logic             err;

    modport master (
        output alloc_req, commit_alloc, free_valid, free_phy, flush,
        input  alloc_gnt, alloc_phy, empty, free_count, err
    );
    modport slave (
        input  alloc_req, commit_alloc, free_valid, free_phy, flush,
        output alloc_gnt, alloc_phy, empty, free_count, err
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular free list of physical tags with speculative head,
// committed head and tail pointers; flush rewinds the head in one cycle.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    phys_reg_free_list_if.slave fl
);
    phy_tag_t  r_fifo [DEPTH];
    free_ptr_t r_head;
    free_ptr_t r_commit_head;
    free_ptr_t r_tail;
    logic      r_err;

    free_ptr_t w_free_count;
    free_ptr_t w_commit_next;
    logic      w_empty;
    logic      w_gnt;
    logic      w_commit_ok;
    logic      w_free_ok;

    assign w_free_count  = r_tail - r_head;
    assign w_empty       = (w_free_count == '0);
    assign w_gnt         = fl.alloc_req && !w_empty && !fl.flush;
    assign w_commit_ok   = fl.commit_alloc && (r_commit_head != r_head);
    assign w_commit_next = r_commit_head + free_ptr_t'(w_commit_ok);
    // Capacity is judged against the committed head after this cycle's retirement,
    // since the ROB returns the old mapping alongside the retiring allocation.
    assign w_free_ok     = fl.free_valid && ((r_tail - w_commit_next) != free_ptr_t'(DEPTH));

    assign fl.alloc_gnt  = w_gnt;
    assign fl.alloc_phy  = r_fifo[ptr_idx(r_head)];
    assign fl.empty      = w_empty;
    assign fl.free_count = (PHY_W+1)'(w_free_count);
    assign fl.err        = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head        <= '0;
            r_commit_head <= '0;
            r_tail        <= free_ptr_t'(DEPTH);
            r_err         <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                r_fifo[i] <= phy_tag_t'(NUM_ARCH + i);
        end else begin
            if (w_free_ok) begin
                r_fifo[ptr_idx(r_tail)] <= fl.free_phy;
                r_tail                  <= r_tail + free_ptr_t'(1);
            end
            r_commit_head <= w_commit_next;
            r_head        <= fl.flush ? w_commit_next : r_head + free_ptr_t'(w_gnt);
            r_err         <= r_err | (fl.commit_alloc && !w_commit_ok) | (fl.free_valid && !w_free_ok);
        end
    end
endmodule
